bus_arbiter: RTL

- Shares the single 32-bit system bus slave port between N_REQ masters (e.g. CPU fetch, CPU load/store, VGA line fetch) using round-robin arbitration.
- Registers the winning request onto the bus and holds it until the slave responds or a timeout expires.
- Returns read data, ack or error to the granted master only.
- Sits between the masters and the address decoder / memory interconnect.

---
 rtl/bus_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter sharing one 32-bit system bus slave port
//
// Purpose:
//   Shares the single bus slave port between N_REQ masters. It picks a winner
//   round-robin and registers its request onto the bus. It holds that request
//   until the slave answers or TIMEOUT cycles pass. It then returns ack, or err,
//   to the granted master only.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req[N_REQ]        per-master level request, held until ack or err
//   req_we[N_REQ]     per-master write enable
//   req_addr          per-master address, master i at [32*i+31:32*i]
//   req_wdata         per-master write data, same packing as req_addr
//   ack[N_REQ]        one-cycle completion pulse to the granted master
//   err[N_REQ]        one-cycle timeout pulse to the granted master
//   rdata             read data, valid while ack is high, held until next completion
//   bus_valid         transfer request to the slave
//   bus_we            transfer direction
//   bus_addr          transfer address
//   bus_wdata         transfer write data
//   bus_rdata         slave read data, sampled when bus_ready=1
//   bus_ready         slave completion, single-cycle or held
//   grant_id          index of the current or last granted master

module bus_arbiter #(
   parameter int N_REQ   = 3,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         req_we,
   input  logic [N_REQ*32-1:0]      req_addr,
   input  logic [N_REQ*32-1:0]      req_wdata,
   output logic [N_REQ-1:0]         ack,
   output logic [N_REQ-1:0]         err,
   output logic [31:0]              rdata,
   output logic                     bus_valid,
   output logic                     bus_we,
   output logic [31:0]              bus_addr,
   output logic [31:0]              bus_wdata,
   input  logic [31:0]              bus_rdata,
   input  logic                     bus_ready,
   output logic [$clog2(N_REQ)-1:0] grant_id
);

   localparam int GW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;

   logic [GW-1:0]  rr;          // highest-priority index for the next arbitration
   logic [CW-1:0]  cnt;         // BUSY cycles elapsed, cleared on entry to BUSY
   logic           resp_ok;     // 1: last completion was ack, 0: timeout

   logic           any_req;
   logic [GW-1:0]  win_id;
   logic [GW-1:0]  win_nxt;
   logic [GW:0]    scan;
   logic           sel_we;
   logic [31:0]    sel_addr;
   logic [31:0]    sel_wdata;
   logic           done_ready;
   logic           done_timeout;

   // Round-robin search: first set req bit starting at rr, wrapping past N_REQ-1.
   // scan has one spare bit so rr+i never overflows before the wrap subtraction.
   always_comb begin
      any_req = 1'b0;
      win_id  = '0;
      scan    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         scan = {1'b0, rr} + (GW+1)'(i);
         if (scan >= (GW+1)'(N_REQ)) begin
            scan = scan - (GW+1)'(N_REQ);
         end
         if (!any_req && req[scan[GW-1:0]]) begin
            any_req = 1'b1;
            win_id  = scan[GW-1:0];
         end
      end
   end

   always_comb begin
      win_nxt = (win_id == GW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
   end

   // Winner's request fields, muxed with constant slices.
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_id == GW'(i)) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[32*i +: 32];
            sel_wdata = req_wdata[32*i +: 32];
         end
      end
   end

   // A ready that lands on the last allowed cycle still counts as success.
   assign done_ready   = (state == BUSY) && bus_ready;
   assign done_timeout = (state == BUSY) && !bus_ready && (cnt == CNT_LAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (any_req) state_nxt = BUSY;
         BUSY: if (done_ready || done_timeout) state_nxt = RESP;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath registers.
   // The winner's fields are captured only on the IDLE->BUSY edge.
   // Master changes after that edge never reach the bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr        <= '0;
         grant_id  <= '0;
         cnt       <= '0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         rdata     <= '0;
         resp_ok   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_id  <= win_id;
                  rr        <= win_nxt;
                  cnt       <= '0;
                  bus_we    <= sel_we;
                  bus_addr  <= sel_addr;
                  bus_wdata <= sel_wdata;
               end
            end
            BUSY: begin
               // cnt tops out at TIMEOUT-1 before leaving BUSY, so +1 always fits.
               cnt <= cnt + 1'b1;
               if (done_ready) begin
                  rdata   <= bus_rdata;
                  resp_ok <= 1'b1;
               end else if (done_timeout) begin
                  rdata   <= '0;
                  resp_ok <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs.
   // bus_valid decodes straight from the state flop, so it drops with async reset.
   // ack/err are one-hot on grant_id for the single RESP cycle.
   always_comb begin
      bus_valid = (state == BUSY);
      ack       = '0;
      err       = '0;
      if (state == RESP) begin
         if (resp_ok) begin
            ack[grant_id] = 1'b1;
         end else begin
            err[grant_id] = 1'b1;
         end
      end
   end

endmodule
